// File: rtl/imm_extend_pipe.sv
// Immediate extraction and extension for NLANE lanes, registered into a two-entry skid buffer.
// Latency is one cycle into an empty buffer; o_ready depends only on occupancy, never on i_ready.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int NLANE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3*NLANE-1:0]    i_fmt,
  input  logic [25*NLANE-1:0]   i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN*NLANE-1:0] o_imm,
  output logic [NLANE-1:0]      o_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_t;

  localparam logic [2:0] FMT_RT = 3'd0;
  localparam logic [2:0] FMT_IT = 3'd1;
  localparam logic [2:0] FMT_ST = 3'd2;
  localparam logic [2:0] FMT_BT = 3'd3;
  localparam logic [2:0] FMT_JT = 3'd4;
  localparam logic [2:0] FMT_UT = 3'd5;
  localparam logic [2:0] FMT_ZT = 3'd6;
  localparam logic [2:0] FMT_BAD = 3'd7;

  count_t                 count;
  logic [XLEN*NLANE-1:0]  head_imm;
  logic [XLEN*NLANE-1:0]  sec_imm;
  logic [XLEN*NLANE-1:0]  ext_imm;
  logic [NLANE-1:0]       head_err;
  logic [NLANE-1:0]       sec_err;
  logic [NLANE-1:0]       ext_err;
  logic                   push;
  logic                   pop;

  // Every format fits a sign-extended 32-bit value (ZT has bit 31 clear),
  // so widening to XLEN is a single signed resize.
  function automatic logic [XLEN-1:0] extend(input logic [2:0] fmt, input logic [31:7] ins);
    logic [31:0] v;
    v = '0;
    case (fmt)
      FMT_RT:  v = {{20{ins[31]}}, ins[31:25], 5'b0};
      FMT_IT:  v = {{20{ins[31]}}, ins[31:20]};
      FMT_ST:  v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_BT:  v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_JT:  v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_UT:  v = {ins[31:12], 12'b0};
      FMT_ZT:  v = {27'b0, ins[19:15]};
      default: v = '0;
    endcase
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    ext_imm = '0;
    ext_err = '0;
    for (int k = 0; k < NLANE; k++) begin
      ext_imm[XLEN*k +: XLEN] = extend(i_fmt[3*k +: 3], i_data[25*k +: 25]);
      ext_err[k]              = (i_fmt[3*k +: 3] == FMT_BAD);
    end
  end

  assign o_ready = (count != FULL);
  assign o_valid = (count != EMPTY);
  assign o_imm   = head_imm;
  assign o_err   = head_err;
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count    <= EMPTY;
      head_imm <= '0;
      head_err <= '0;
      sec_imm  <= '0;
      sec_err  <= '0;
    end else if (i_flush) begin
      count <= EMPTY;
    end else begin
      case (count)
        EMPTY: begin
          if (push) begin
            head_imm <= ext_imm;
            head_err <= ext_err;
            count    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_imm <= ext_imm;
            head_err <= ext_err;
          end else if (push) begin
            sec_imm <= ext_imm;
            sec_err <= ext_err;
            count   <= FULL;
          end else if (pop) begin
            count <= EMPTY;
          end
        end
        FULL: begin
          // Upstream is already stalled here, so only a pop can change state.
          if (pop) begin
            head_imm <= sec_imm;
            head_err <= sec_err;
            count    <= ONE;
          end
        end
        default: count <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 32-bit single-lane and a 64-bit dual-lane instance share control.
module tb_imm_extend_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         valid;
  logic         ready;
  logic [2:0]   fmt32;
  logic [24:0]  data32;
  logic [5:0]   fmt64;
  logic [49:0]  data64;
  logic         o_ready32, o_valid32, o_ready64, o_valid64;
  logic [31:0]  imm32;
  logic [0:0]   err32;
  logic [127:0] imm64;
  logic [1:0]   err64;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]  imm32;
    logic         err32;
    logic [127:0] imm64;
    logic [1:0]   err64;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .NLANE(1)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready32),
    .i_fmt(fmt32), .i_data(data32), .o_valid(o_valid32), .i_ready(ready),
    .o_imm(imm32), .o_err(err32)
  );

  imm_extend_pipe #(.XLEN(64), .NLANE(2)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready64),
    .i_fmt(fmt64), .i_data(data64), .o_valid(o_valid64), .i_ready(ready),
    .o_imm(imm64), .o_err(err64)
  );

  function automatic logic [63:0] ref64(input logic [2:0] f, input logic [31:0] ins);
    logic s;
    s = ins[31];
    case (f)
      3'd0:    return {{52{s}}, ins[31:25], 5'b0};
      3'd1:    return {{52{s}}, ins[31:20]};
      3'd2:    return {{52{s}}, ins[31:25], ins[11:7]};
      3'd3:    return {{52{s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd4:    return {{44{s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5:    return {{32{s}}, ins[31:12], 12'b0};
      3'd6:    return {59'b0, ins[19:15]};
      default: return 64'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input exp_t e);
    check({tag, "_imm32"}, imm32, e.imm32);
    check({tag, "_err32"}, err32, e.err32);
    check({tag, "_imm64"}, imm64, e.imm64);
    check({tag, "_err64"}, err64, e.err64);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid32"}, o_valid32, q.size() != 0);
    check({tag, "_ready32"}, o_ready32, q.size() < 2);
    check({tag, "_valid64"}, o_valid64, q.size() != 0);
    check({tag, "_ready64"}, o_ready64, q.size() < 2);
  endtask

  // Called at posedge+1; drives one cycle of stimulus and scores the edge.
  task automatic step(input logic v, input logic [2:0] f0, input logic [31:0] i0,
                      input logic [2:0] f1, input logic [31:0] i1,
                      input logic rdy, input logic fl);
    logic push, pop;
    logic [63:0] r0, r1;
    exp_t e;
    valid  = v;
    ready  = rdy;
    flush  = fl;
    fmt32  = f0;
    data32 = i0[31:7];
    fmt64  = {f1, f0};
    data64 = {i1[31:7], i0[31:7]};
    #1;
    push = v && o_ready32;
    pop  = o_valid32 && rdy;
    if (o_valid32 && q.size() > 0) begin
      check_head("head", q[0]);
      if (pop && !fl) void'(q.pop_front());
    end
    r0 = ref64(f0, i0);
    r1 = ref64(f1, i1);
    e.imm32 = r0[31:0];
    e.err32 = (f0 == 3'd7);
    e.imm64 = {r1, r0};
    e.err64 = {f1 == 3'd7, f0 == 3'd7};
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else if (push) q.push_back(e);
    check_state("occ");
  endtask

  // Single-lane shorthand; lane 1 of the wide instance gets a derived variant.
  task automatic g(input logic v, input logic [2:0] f0, input logic [31:0] i0,
                   input logic rdy, input logic fl);
    step(v, f0, i0, f0 ^ 3'd5, {i0[15:0], i0[31:16]}, rdy, fl);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    fmt32 = '0;
    data32 = '0;
    fmt64 = '0;
    data64 = '0;
    #2;
    check("rst_valid32", o_valid32, 1'b0);
    check("rst_ready32", o_ready32, 1'b1);
    check("rst_imm32", imm32, 32'h0);
    check("rst_err32", err32, 1'b0);
    check("rst_valid64", o_valid64, 1'b0);
    check("rst_ready64", o_ready64, 1'b1);
    check("rst_imm64", imm64, 128'h0);
    check("rst_err64", err64, 2'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming, back-to-back, one-cycle latency
    step(1, 3'd1, 32'hFFF00093, 3'd6, 32'h000FD073, 1, 0);
    check("it_const", imm32, 32'hFFFFFFFF);
    check("zt_const", imm64[127:64], 64'h1F);
    step(1, 3'd3, 32'hFE000EE3, 3'd5, 32'h800000B7, 1, 0);
    check("bt_const", imm32, 32'hFFFFFFFC);
    check("ut_neg_const", imm64[127:64], 64'hFFFFFFFF80000000);
    step(1, 3'd4, 32'h0040006F, 3'd5, 32'h123450B7, 1, 0);
    check("jt_const", imm32, 32'h00000004);
    check("ut_pos_const", imm64[127:64], 64'h0000000012345000);
    step(1, 3'd5, 32'h800000B7, 3'd7, 32'hDEADBEEF, 1, 0);
    step(1, 3'd7, 32'h12345678, 3'd1, 32'h00100093, 1, 0);
    check("bad_imm", imm64[63:0], 64'h0);
    check("bad_err", err64, 2'b01);
    check("neighbour_imm", imm64[127:64], 64'h1);
    step(1, 3'd0, 32'h80000033, 3'd2, 32'hFE112E23, 1, 0);
    step(1, 3'd2, 32'h00112423, 3'd0, 32'h40000033, 1, 0);
    g(0, 3'd0, 32'h0, 1, 0);
    g(0, 3'd0, 32'h0, 1, 0);

    // Backpressure: A and B accepted, C held upstream until space frees
    g(1, 3'd1, 32'h00500093, 0, 0);
    g(1, 3'd1, 32'h00600093, 0, 0);
    g(1, 3'd1, 32'h00700093, 0, 0);
    g(1, 3'd1, 32'h00700093, 0, 0);
    g(1, 3'd1, 32'h00700093, 1, 0);
    g(1, 3'd1, 32'h00700093, 1, 0);
    g(0, 3'd0, 32'h0, 1, 0);
    g(0, 3'd0, 32'h0, 1, 0);

    // Simultaneous push and pop while holding one entry
    g(1, 3'd4, 32'hFFDFF0EF, 1, 0);
    g(1, 3'd3, 32'h00208463, 1, 0);
    g(0, 3'd0, 32'h0, 1, 0);

    // Flush while full, flush with push into empty, flush with push+pop in ONE
    g(1, 3'd2, 32'h00A12023, 0, 0);
    g(1, 3'd5, 32'hABCDE037, 0, 0);
    g(1, 3'd1, 32'h7FF00093, 0, 1);
    g(1, 3'd1, 32'h80000093, 1, 1);
    g(1, 3'd6, 32'h00005073, 0, 0);
    g(1, 3'd0, 32'hC0000033, 1, 1);
    g(0, 3'd0, 32'h0, 1, 0);

    // Asynchronous reset between edges while full
    g(1, 3'd1, 32'h12300093, 0, 0);
    g(1, 3'd4, 32'h8000006F, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_valid32", o_valid32, 1'b0);
    check("arst_ready32", o_ready32, 1'b1);
    check("arst_imm32", imm32, 32'h0);
    check("arst_err32", err32, 1'b0);
    check("arst_valid64", o_valid64, 1'b0);
    check("arst_imm64", imm64, 128'h0);
    check("arst_err64", err64, 2'b0);
    q.delete();
    #1 rst_n = 1'b1;
    g(1, 3'd3, 32'h80000863, 1, 0);
    g(0, 3'd0, 32'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
